// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   IF-stage gshare direction predictor with a direct-mapped BTB. Lookup is
//   purely combinational on if_pc and current state. Training comes from EX
//   when a control transfer resolves; the GHR is rebuilt from the history
//   carried with that instruction, so a mispredict recovers it for free.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   if_pc                 PC being fetched
//   pred_taken            next-PC select condition
//   pred_target           BTB target for if_pc's slot (valid or not)
//   btb_hit               BTB slot valid and tag match
//   pred_ghr              GHR used for this lookup, travels with the insn
//   update_*              EX resolution info (PC, carried ghr/prediction)
//   actual_taken/_target  resolved outcome
//   mispredict            same-cycle flush request to hazard logic
// ---------------------------------------------------------------------------

// One BTB slot: valid bit, tag and target. Only written on a taken update.
module bp_btb_entry #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [DATA_WIDTH-1:0] wr_target_i,
  output logic                  valid_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic [DATA_WIDTH-1:0] target_o
);
  logic                  valid_q;
  logic [TAG_W-1:0]      tag_q;
  logic [DATA_WIDTH-1:0] target_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      target_q <= '0;
    end else if (wr_en_i) begin
      valid_q  <= 1'b1;
      tag_q    <= wr_tag_i;
      target_q <= wr_target_i;
    end
  end

  assign valid_o  = valid_q;
  assign tag_o    = tag_q;
  assign target_o = target_q;
endmodule

// One BHT slot: 2-bit saturating counter, resets to weakly not-taken.
module bp_bht_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd_en_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);
  logic [1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (upd_en_i) begin
      if (taken_i && (ctr_q != 2'b11))       ctr_d = ctr_q + 2'd1;
      else if (!taken_i && (ctr_q != 2'b00)) ctr_d = ctr_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctr_q <= 2'b01;
    else       ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;
endmodule

module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4,
  parameter int HIST_BITS  = 4   // must equal INDEX_BITS (gshare XOR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  output logic                  btb_hit,
  output logic [HIST_BITS-1:0]  pred_ghr,
  input  logic                  update_valid,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic [HIST_BITS-1:0]  update_ghr,
  input  logic                  update_pred_taken,
  input  logic [DATA_WIDTH-1:0] update_pred_target,
  input  logic                  actual_taken,
  input  logic [DATA_WIDTH-1:0] actual_target,
  output logic                  mispredict
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

  // Per-entry state, flattened for indexed reads
  logic [ENTRIES-1:0]                 btb_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]      btb_tag;
  logic [ENTRIES-1:0][DATA_WIDTH-1:0] btb_target;
  logic [ENTRIES-1:0][1:0]            bht_ctr;
  logic [ENTRIES-1:0]                 btb_we;
  logic [ENTRIES-1:0]                 bht_we;

  logic [HIST_BITS-1:0]  ghr_q, ghr_d;

  // Lookup side
  logic [INDEX_BITS-1:0] lk_btb_idx, lk_bht_idx;
  logic [TAG_W-1:0]      lk_tag;
  // Update side
  logic [INDEX_BITS-1:0] up_btb_idx, up_bht_idx;
  logic [TAG_W-1:0]      up_tag;

  assign lk_btb_idx = if_pc[INDEX_BITS+1:2];
  assign lk_tag     = if_pc[DATA_WIDTH-1:INDEX_BITS+2];
  assign lk_bht_idx = lk_btb_idx ^ INDEX_BITS'(ghr_q);

  assign up_btb_idx = update_pc[INDEX_BITS+1:2];
  assign up_tag     = update_pc[DATA_WIDTH-1:INDEX_BITS+2];
  // Index with the history the branch was predicted under, not current ghr
  assign up_bht_idx = up_btb_idx ^ INDEX_BITS'(update_ghr);

  // Reads see pre-update state; writes land at the edge (no bypass)
  assign btb_hit     = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
  assign pred_taken  = btb_hit && bht_ctr[lk_bht_idx][1];
  assign pred_target = btb_target[lk_btb_idx];
  assign pred_ghr    = ghr_q;

  assign mispredict = update_valid &&
                      ((update_pred_taken != actual_taken) ||
                       (actual_taken && (update_pred_target != actual_target)));

  // Not-taken updates never touch the BTB, so stale entries survive
  always_comb begin
    btb_we = '0;
    bht_we = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      btb_we[i] = update_valid && actual_taken && (up_btb_idx == INDEX_BITS'(i));
      bht_we[i] = update_valid && (up_bht_idx == INDEX_BITS'(i));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      bp_btb_entry #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_W      (TAG_W)
      ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (btb_we[gi]),
        .wr_tag_i    (up_tag),
        .wr_target_i (actual_target),
        .valid_o     (btb_valid[gi]),
        .tag_o       (btb_tag[gi]),
        .target_o    (btb_target[gi])
      );

      bp_bht_ctr u_bht (
        .clk      (clk),
        .reset    (reset),
        .upd_en_i (bht_we[gi]),
        .taken_i  (actual_taken),
        .ctr_o    (bht_ctr[gi])
      );
    end
  endgenerate

  // Rebuilt from the carried history so a flush restores the correct path
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid) ghr_d = {update_ghr[HIST_BITS-2:0], actual_taken};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  // Byte-offset bits and the history MSB shifted out are intentionally unused
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], update_pc[1:0], update_ghr[HIST_BITS-1]};
endmodule
